// File: rtl/tdc_window_ctrl.sv
// TDC measurement-window sequencer: start trigger opens a programmable window and
// drives per-channel stop-disable gates, master reset, data-save strobe and a shot counter.

module tdc_ch_gate (
  input  logic en,
  input  logic in_stop,
  output logic dis
);
  assign dis = en & in_stop;
endmodule

module tdc_window_ctrl #(
  parameter int CNT_W      = 32,
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 8192,
  parameter int SHOT_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tstart_tri,
  input  logic [CNT_W-1:0]  cfg_test_time,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_save_ofs,
  input  logic [CNT_W-1:0]  cfg_mrst_start,
  input  logic [CNT_W-1:0]  cfg_mrst_len,
  input  logic [N_CH-1:0]   cfg_ch_en,
  input  logic              cfg_auto,
  output logic              busy,
  output logic [CNT_W-1:0]  t_cnt,
  output logic [N_CH-1:0]   stop_dis,
  output logic              master_rst,
  output logic              data_save,
  output logic [SHOT_W-1:0] shot_cnt,
  output logic              shot_wrap,
  output logic              trig_drop,
  output logic              cfg_err
);

  typedef struct packed {
    logic [CNT_W-1:0] test_time;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] save_ofs;
    logic [CNT_W-1:0] mrst_start;
    logic [CNT_W-1:0] mrst_len;
    logic [N_CH-1:0]  ch_en;
  } cfg_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] t, t_nx;
  cfg_t             cfg_l, cfg_live;
  logic             cfg_ok, latch, drop_nx, err_nx;
  logic             in_stop;
  logic [CNT_W:0]   save_at, mrst_end, t_x;

  assign cfg_live = '{test_time:  cfg_test_time,
                      period:     cfg_period,
                      save_ofs:   cfg_save_ofs,
                      mrst_start: cfg_mrst_start,
                      mrst_len:   cfg_mrst_len,
                      ch_en:      cfg_ch_en};

  assign cfg_ok = (cfg_period != '0) && (cfg_test_time < cfg_period);

  // State register plus the window counter and latched config it owns
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      t     <= '0;
      cfg_l <= '0;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      if (latch) cfg_l <= cfg_live;
    end
  end

  always_comb begin
    state_nx = state;
    t_nx     = t;
    latch    = 1'b0;
    drop_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (tstart_tri) begin
          if (cfg_ok) begin
            state_nx = RUN;
            t_nx     = CNT_W'(1);
            latch    = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      RUN: begin
        drop_nx = tstart_tri;
        if (t == cfg_l.period) begin
          // Free-run re-arms straight into t=1 with freshly latched config
          if (cfg_auto && cfg_ok) begin
            t_nx  = CNT_W'(1);
            latch = 1'b1;
          end else begin
            state_nx = IDLE;
            t_nx     = '0;
            err_nx   = cfg_auto;
          end
        end else begin
          t_nx = t + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        t_nx     = '0;
      end
    endcase
  end

  // Decodes use only registered count and latched config; sums are one bit wider
  assign t_x      = {1'b0, t};
  assign save_at  = {1'b0, cfg_l.test_time}  + {1'b0, cfg_l.save_ofs};
  assign mrst_end = {1'b0, cfg_l.mrst_start} + {1'b0, cfg_l.mrst_len};

  always_comb begin
    busy       = 1'b0;
    in_stop    = 1'b0;
    data_save  = 1'b0;
    master_rst = 1'b0;
    if (t != '0) begin
      busy       = 1'b1;
      in_stop    = (t > cfg_l.test_time) && (t <= cfg_l.period);
      data_save  = (t_x == save_at);
      master_rst = (t >= cfg_l.mrst_start) && (t_x < mrst_end);
    end
  end

  assign t_cnt = t;

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      tdc_ch_gate u_gate (
        .en      (cfg_l.ch_en[i]),
        .in_stop (in_stop),
        .dis     (stop_dis[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      trig_drop <= 1'b0;
      cfg_err   <= 1'b0;
      shot_cnt  <= '0;
      shot_wrap <= 1'b0;
    end else begin
      trig_drop <= drop_nx;
      cfg_err   <= err_nx;
      shot_wrap <= 1'b0;
      if (data_save) begin
        if (shot_cnt == SHOT_W'(FIFO_DEPTH - 1)) begin
          shot_cnt  <= '0;
          shot_wrap <= 1'b1;
        end else begin
          shot_cnt <= shot_cnt + SHOT_W'(1);
        end
      end
    end
  end

endmodule
